// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_responder
//  Description : Single-outstanding data memory responder with a fixed
//                request-to-response latency. DEPTH doublewords of storage,
//                word index taken from addr[3 +: log2(DEPTH)].
//                Optional misaligned-access error checking is enabled by
//                defining the macro ALIGN_CHECK_EN.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                req_valid/req_ready   - request handshake
//                req_write/addr/wdata  - request payload (byte address)
//                resp_valid/resp_ready - response handshake
//                resp_rdata/resp_err   - load data (0 for stores), error flag
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int         c_IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] c_WAIT_LOAD = 4'(LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic               r_write;
    logic [c_IDX_W-1:0] r_idx;
    logic [63:0]        r_wdata;
    logic [63:0]        r_rdata;
    logic [63:0]        r_mem [DEPTH];

    logic               w_idle;
    logic               w_accept;
    logic               w_enter_resp;
    logic               w_acc_write;
    logic [c_IDX_W-1:0] w_acc_idx;
    logic [63:0]        w_acc_wdata;
    logic               w_acc_err;

    // Address bits outside the index field never affect storage.
    logic w_unused_addr;
    assign w_unused_addr = ^{req_addr[63:3+c_IDX_W], req_addr[2:0]};

    assign w_idle       = (r_state == c_IDLE);
    assign w_accept     = w_idle && req_valid;
    assign req_ready    = w_idle;
    assign resp_valid   = (r_state == c_RESP);
    assign resp_rdata   = r_rdata;

    // With LATENCY=1 the memory access happens on the acceptance edge itself,
    // so the request fields are taken straight from the ports in IDLE and
    // from the latched copies otherwise.
    assign w_enter_resp = (w_accept && (LATENCY == 1)) ||
                          ((r_state == c_WAIT) && (r_cnt == 4'd1));
    assign w_acc_write  = w_idle ? req_write             : r_write;
    assign w_acc_idx    = w_idle ? req_addr[3 +: c_IDX_W] : r_idx;
    assign w_acc_wdata  = w_idle ? req_wdata             : r_wdata;

`ifdef ALIGN_CHECK_EN
    logic r_misalign;
    logic r_err;

    assign w_acc_err = w_idle ? (req_addr[2:0] != 3'b000) : r_misalign;
    assign resp_err  = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_misalign <= (req_addr[2:0] != 3'b000);
            end
            if (w_enter_resp) begin
                r_err <= w_acc_err;
            end
        end
    end
`else
    assign w_acc_err = 1'b0;
    assign resp_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 64'd0;
            r_rdata <= 64'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 64'd0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_idx   <= req_addr[3 +: c_IDX_W];
                        r_wdata <= req_wdata;
                        if (LATENCY == 1) begin
                            r_state <= c_RESP;
                        end else begin
                            r_state <= c_WAIT;
                            r_cnt   <= c_WAIT_LOAD;
                        end
                    end
                end
                c_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (resp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            // Single memory access per request, on the edge entering RESP;
            // rdata/err then stay frozen for the whole RESP period.
            if (w_enter_resp) begin
                if (w_acc_write && !w_acc_err) begin
                    r_mem[w_acc_idx] <= w_acc_wdata;
                end
                r_rdata <= (w_acc_write || w_acc_err) ? 64'd0 : r_mem[w_acc_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_responder
//  Description : Self-checking bench for data_memory_responder. Directed
//                scenarios plus randomized loads/stores compared against an
//                array-based reference memory. Honors ALIGN_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int n_err = 0;
    int n_chk = 0;

    logic [63:0] mdl [DEPTH];

    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int word_of(input logic [63:0] a);
        return int'((a / 64'd8) % 64'(DEPTH));
    endfunction

    function automatic bit misaligned(input logic [63:0] a);
`ifdef ALIGN_CHECK_EN
        return (a % 64'd8) != 64'd0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 64'd0;
    endtask

    task automatic scramble_req();
        req_write = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
    endtask

    // Wait for resp_valid with a bounded budget; returns edges waited.
    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    // One complete request/response transaction checked against the model.
    task automatic xact(input bit wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input int hold);
        bit          e_err;
        logic [63:0] e_rdata;
        int          n;
        e_err   = misaligned(addr);
        e_rdata = (wr || e_err) ? 64'd0 : mdl[word_of(addr)];

        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        scramble_req();
        wait_resp(n);
        check("latency", 64'(n), 64'(LATENCY - 1));
        check("resp_valid", {63'd0, resp_valid}, 64'd1);
        check("resp_rdata", resp_rdata, e_rdata);
        check("resp_err", {63'd0, resp_err}, {63'd0, e_err});
        check("req_ready_resp", {63'd0, req_ready}, 64'd0);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            tick();
            check("hold_valid", {63'd0, resp_valid}, 64'd1);
            check("hold_rdata", resp_rdata, e_rdata);
            check("hold_err", {63'd0, resp_err}, {63'd0, e_err});
            check("hold_ready", {63'd0, req_ready}, 64'd0);
        end
        // A request presented on the consume edge must not be taken.
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        tick();
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        check("release_valid", {63'd0, resp_valid}, 64'd0);
        check("release_ready", {63'd0, req_ready}, 64'd1);
        if (wr && !e_err) mdl[word_of(addr)] = wdata;
    endtask

    initial begin
        logic [63:0] a;
        int          n;

        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        scramble_req();
        tick();
        tick();
        reset = 1'b0;
        clear_model();
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_err", {63'd0, resp_err}, 64'd0);

        // Directed scenarios
        xact(1'b0, 64'h18, 64'd0, 0);
        xact(1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, 0);
        xact(1'b0, 64'h10, 64'd0, 0);
        check("store_load_0x10", mdl[2], 64'hDEAD_BEEF_0123_4567);
        xact(1'b1, 64'h08, 64'hAA, 0);
        xact(1'b0, 64'h208, 64'd0, 0);
        xact(1'b0, 64'h10, 64'd0, 5);

        // Reset while a store is in flight discards it.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'h55;
        tick();
        req_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        check("rstwait_valid", {63'd0, resp_valid}, 64'd0);
        check("rstwait_ready", {63'd0, req_ready}, 64'd1);
        xact(1'b0, 64'h20, 64'd0, 0);

        // Misaligned store, then the containing word.
        xact(1'b1, 64'h08, 64'h77, 0);
        xact(1'b1, 64'h0C, 64'h1234, 1);
        xact(1'b0, 64'h08, 64'd0, 0);

        // Reset in RESP wins over simultaneous req_valid/resp_ready.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h08;
        tick();
        req_valid = 1'b0;
        wait_resp(n);
        check("rstresp_pre", {63'd0, resp_valid}, 64'd1);
        reset      = 1'b1;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        tick();
        reset      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        clear_model();
        check("rstresp_valid", {63'd0, resp_valid}, 64'd0);
        check("rstresp_ready", {63'd0, req_ready}, 64'd1);
        check("rstresp_rdata", resp_rdata, 64'd0);
        xact(1'b0, 64'h08, 64'd0, 0);

        // Randomized traffic, biased towards a few words to get hits.
        for (int t = 0; t < 80; t++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(3) != 0) a[2:0] = 3'b000;
            if ($urandom_range(1) != 0) a[8:3] = 6'($urandom_range(7));
            xact(1'($urandom), a, {$urandom, $urandom}, $urandom_range(2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
